// File: rtl/latent_vector_streamer_if.sv
// Serial latent-element stream between the latent vector streamer and the
// generator layer-1 input FIFO.
//
// Signals:
//   out_data   element value, Q8.8 signed        (master -> slave)
//   out_valid  data/index/last are valid         (master -> slave)
//   out_ready  slave accepts this cycle          (slave -> master)
//   out_index  element position within the frame (master -> slave)
//   out_last   final element of the frame        (master -> slave)
interface latent_vector_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 6
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_W-1:0]      out_index;
    logic                  out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/latent_vector_streamer.sv
// Latent vector streamer: captures the packed Q8.8 latent bank on the seed
// bank's one-cycle done pulse, then emits every element, arithmetically
// shifted right by SHIFT, as a valid/ready stream with index and last markers.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   seed_flat   packed bank, element i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   seed_done   one-cycle pulse, seed_flat valid in the same cycle
//   outIf       stream master (out_data/out_valid/out_index/out_last/out_ready)
//   busy        a captured frame is not yet fully delivered
//   frame_done  one-cycle pulse after the last element is accepted
//   overrun     sticky, seed_done arrived while busy; cleared only by rst
module latent_vector_streamer #(
    parameter int SEED_COUNT = 64,
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT      = 7,
    localparam int IDX_W     = $clog2(SEED_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH*SEED_COUNT-1:0] seed_flat,
    input  logic                             seed_done,
    latent_vector_streamer_if.master         outIf,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEED_COUNT - 1);

    typedef enum logic [0:0] {
        IDLE,
        STREAM
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] capture_q [SEED_COUNT];
    logic [IDX_W-1:0]      index_q;
    logic [DATA_WIDTH-1:0] outData_q;
    logic                  outValid_q;
    logic                  outLast_q;
    logic                  busy_q;
    logic                  frameDone_q;
    logic                  overrun_q;
    logic [IDX_W-1:0]      nextIdx_d;

    // Scale into [-1.0, +1.0): sign-preserving shift, width unchanged.
    function automatic logic [DATA_WIDTH-1:0] scaleElem(input logic [DATA_WIDTH-1:0] e);
        logic signed [DATA_WIDTH-1:0] s;
        s = $signed(e);
        return s >>> SHIFT;
    endfunction

    // Only used while not on the last element, so it never passes SEED_COUNT-1.
    always_comb begin
        nextIdx_d = index_q + 1'b1;
    end

    // Control FSM and all registered outputs. The next element is fetched from
    // the capture register on each non-last handshake, so out_ready only
    // affects register enables and never reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < SEED_COUNT; i++) begin
                capture_q[i] <= '0;
            end
            index_q     <= '0;
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frameDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (seed_done) begin
                        for (int i = 0; i < SEED_COUNT; i++) begin
                            capture_q[i] <= seed_flat[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        // Element 0 goes straight from the bank so it is
                        // presented one cycle after the pulse.
                        index_q    <= '0;
                        outData_q  <= scaleElem(seed_flat[DATA_WIDTH-1:0]);
                        outValid_q <= 1'b1;
                        outLast_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= STREAM;
                    end
                end
                STREAM: begin
                    // A new bank while busy (including the final handshake
                    // cycle) is dropped; the capture register is left alone.
                    if (seed_done) begin
                        overrun_q <= 1'b1;
                    end
                    if (outIf.out_ready) begin
                        if (outLast_q) begin
                            state_q     <= IDLE;
                            outValid_q  <= 1'b0;
                            outLast_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            frameDone_q <= 1'b1;
                        end else begin
                            index_q   <= nextIdx_d;
                            outData_q <= scaleElem(capture_q[nextIdx_d]);
                            outLast_q <= (nextIdx_d == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign outIf.out_data  = outData_q;
    assign outIf.out_valid = outValid_q;
    assign outIf.out_index = index_q;
    assign outIf.out_last  = outLast_q;
    assign busy            = busy_q;
    assign frame_done      = frameDone_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_latent_vector_streamer.sv
// Directed testbench for latent_vector_streamer with a 4-element bank and a
// shift of 7: reset values, a full frame, back-to-back frames, backpressure,
// overrun handling and an asynchronous reset in the middle of a frame.
module tb_latent_vector_streamer;

    localparam int SEED_COUNT = 4;
    localparam int DATA_WIDTH = 16;
    localparam int SHIFT      = 7;
    localparam int IDX_W      = 2;

    // Bank A = {0x0100, 0x7FFF, 0x8000, 0xACE1}, bank B = {0xFF80, 0x0380, 0x1234, 0xFFFF}
    localparam logic [63:0] BANK_A = {16'hACE1, 16'h8000, 16'h7FFF, 16'h0100};
    localparam logic [63:0] EXP_A  = {16'hFF59, 16'hFF00, 16'h00FF, 16'h0002};
    localparam logic [63:0] BANK_B = {16'hFFFF, 16'h1234, 16'h0380, 16'hFF80};
    localparam logic [63:0] EXP_B  = {16'hFFFF, 16'h0024, 16'h0007, 16'hFFFF};

    logic                             clk;
    logic                             rst;
    logic [DATA_WIDTH*SEED_COUNT-1:0] seed_flat;
    logic                             seed_done;
    logic                             busy;
    logic                             frame_done;
    logic                             overrun;

    int vectors;
    int miscompares;

    latent_vector_streamer_if #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) outIf ();

    latent_vector_streamer #(
        .SEED_COUNT(SEED_COUNT),
        .DATA_WIDTH(DATA_WIDTH),
        .SHIFT     (SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_flat (seed_flat),
        .seed_done (seed_done),
        .outIf     (outIf),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] bank);
        seed_flat = bank;
        seed_done = 1'b1;
        tick();
        seed_done = 1'b0;
    endtask

    // Walks a frame with out_ready high; ends in the frame_done cycle.
    task automatic runFrame(input string tag, input logic [63:0] expFlat, input logic expOverrun);
        for (int i = 0; i < SEED_COUNT; i++) begin
            checkOutput({tag, "_valid"}, 32'(outIf.out_valid), 32'd1);
            checkOutput({tag, "_data"},  32'(outIf.out_data),  32'(expFlat[i*16 +: 16]));
            checkOutput({tag, "_index"}, 32'(outIf.out_index), 32'(i));
            checkOutput({tag, "_last"},  32'(outIf.out_last),  32'(i == SEED_COUNT - 1));
            checkOutput({tag, "_busy"},  32'(busy),            32'd1);
            tick();
        end
        checkOutput({tag, "_end_valid"},   32'(outIf.out_valid), 32'd0);
        checkOutput({tag, "_frame_done"},  32'(frame_done),      32'd1);
        checkOutput({tag, "_end_busy"},    32'(busy),            32'd0);
        checkOutput({tag, "_overrun"},     32'(overrun),         32'(expOverrun));
    endtask

    initial begin
        logic pat [4];
        int   hsCount;
        logic hs;
        logic doneSeen;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        seed_done   = 1'b0;
        seed_flat   = '0;
        outIf.out_ready = 1'b0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset values
        #2;
        checkOutput("rst_valid",      32'(outIf.out_valid), 32'd0);
        checkOutput("rst_data",       32'(outIf.out_data),  32'd0);
        checkOutput("rst_index",      32'(outIf.out_index), 32'd0);
        checkOutput("rst_last",       32'(outIf.out_last),  32'd0);
        checkOutput("rst_busy",       32'(busy),            32'd0);
        checkOutput("rst_frame_done", 32'(frame_done),      32'd0);
        checkOutput("rst_overrun",    32'(overrun),         32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("idle_valid", 32'(outIf.out_valid), 32'd0);

        // Basic frame, then a back-to-back frame started in the frame_done cycle
        outIf.out_ready = 1'b1;
        applyStimulus(BANK_A);
        runFrame("basic", EXP_A, 1'b0);
        applyStimulus(BANK_B);
        runFrame("b2b", EXP_B, 1'b0);
        tick();
        checkOutput("b2b_fd_clear", 32'(frame_done), 32'd0);

        // Backpressure with out_ready cycling 1,0,0,1
        applyStimulus(BANK_A);
        hsCount  = 0;
        doneSeen = 1'b0;
        for (int c = 0; c < 40 && !doneSeen; c++) begin
            hs = 1'b0;
            if (outIf.out_valid) begin
                checkOutput("bp_data",  32'(outIf.out_data),  32'(EXP_A[(hsCount % 4)*16 +: 16]));
                checkOutput("bp_index", 32'(outIf.out_index), 32'(hsCount));
                checkOutput("bp_last",  32'(outIf.out_last),  32'(hsCount == SEED_COUNT - 1));
                outIf.out_ready = pat[c % 4];
                hs = outIf.out_ready;
            end else if (frame_done) begin
                doneSeen = 1'b1;
            end
            if (!doneSeen) begin
                tick();
                if (hs) hsCount++;
            end
        end
        checkOutput("bp_handshakes", 32'(hsCount),  32'd4);
        checkOutput("bp_frame_done", 32'(doneSeen), 32'd1);
        outIf.out_ready = 1'b1;
        tick();

        // Overrun: second bank arrives while index 2 is presented
        applyStimulus(BANK_A);
        checkOutput("ovr_d0", 32'(outIf.out_data), 32'h0002);
        tick();
        tick();
        checkOutput("ovr_idx2", 32'(outIf.out_index), 32'd2);
        applyStimulus(BANK_B);
        checkOutput("ovr_d3",   32'(outIf.out_data), 32'hFF59);
        checkOutput("ovr_last", 32'(outIf.out_last), 32'd1);
        checkOutput("ovr_flag", 32'(overrun),        32'd1);
        tick();
        checkOutput("ovr_frame_done", 32'(frame_done), 32'd1);
        applyStimulus(BANK_B);
        runFrame("ovr_fresh", EXP_B, 1'b1);
        tick();

        // Asynchronous reset while index 1 is presented
        applyStimulus(BANK_A);
        tick();
        checkOutput("rmid_idx1", 32'(outIf.out_index), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rmid_valid",   32'(outIf.out_valid), 32'd0);
        checkOutput("rmid_busy",    32'(busy),            32'd0);
        checkOutput("rmid_overrun", 32'(overrun),         32'd0);
        checkOutput("rmid_index",   32'(outIf.out_index), 32'd0);
        checkOutput("rmid_data",    32'(outIf.out_data),  32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rmid_no_fd", 32'(frame_done), 32'd0);
        applyStimulus(BANK_B);
        runFrame("rmid_restart", EXP_B, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
